fc_sequencer: RTL and testbench

Time-multiplexed controller for a fully connected layer. It buffers one input vector, then runs a single signed MAC over external weight and bias memories, one output neuron at a time. For each neuron it applies bias, shift, activation and saturation, then streams the result out under valid/ready. It sits between the previous layer's output stream and the next layer's input, replacing a fully parallel matrix multiply with an area-cheap sequenced datapath.

---
 rtl/fc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_sequencer.sv
// Sequenced fully connected layer: buffers one input vector, then runs a single signed
// MAC per output neuron over external weight/bias memories and streams saturated results.
module fc_sequencer #(
    parameter int    INPUT_SIZE  = 16,
    parameter int    OUTPUT_SIZE = 8,
    parameter int    DATA_W      = 8,
    parameter int    ACC_W       = 24,
    parameter int    SHIFT       = 0,
    parameter string ACTIVATION  = "relu",
    localparam int   WA_W        = $clog2(INPUT_SIZE * OUTPUT_SIZE),
    localparam int   N_W         = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     w_rd_en,
    output logic [WA_W-1:0]          w_addr,
    input  logic signed [DATA_W-1:0] w_rdata,
    output logic                     b_rd_en,
    output logic [N_W-1:0]           b_addr,
    input  logic signed [DATA_W-1:0] b_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [N_W-1:0]           out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int K_W     = $clog2(INPUT_SIZE);
    localparam bit IS_RELU = (ACTIVATION == "relu");
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = IS_RELU ? {ACC_W{1'b0}} :
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} state_t;

    state_t                    state_reg, state_next;
    logic [K_W-1:0]            k_reg, k_next;
    logic [N_W-1:0]            n_reg, n_next;
    logic                      done_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic                      bias_phase_reg;
    logic signed [DATA_W-1:0]  buf_mem [INPUT_SIZE];
    logic signed [DATA_W-1:0]  buf_rd_reg;

    logic                      last_k, last_n;
    logic [2*DATA_W-1:0]       prod;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext, shifted;
    logic signed [DATA_W-1:0]  sat;

    assign last_k = (k_reg == K_W'(INPUT_SIZE - 1));
    assign last_n = (n_reg == N_W'(OUTPUT_SIZE - 1));

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        n_next     = n_reg;
        case (state_reg)
            IDLE: if (start) begin
                state_next = LOAD;
                k_next     = '0;
            end
            LOAD: if (in_valid) begin
                if (last_k) begin
                    state_next = MAC;
                    k_next     = '0;
                    n_next     = '0;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            MAC: begin
                if (last_k) begin
                    state_next = DRAIN;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            DRAIN: state_next = OUT;
            OUT: if (out_ready) begin
                if (last_n) begin
                    state_next = IDLE;
                    n_next     = '0;
                end else begin
                    state_next = MAC;
                    n_next     = n_reg + 1'b1;
                    k_next     = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            n_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            n_reg     <= n_next;
            done_reg  <= (state_reg == OUT) && out_ready && last_n;
        end
    end

    // Registered buffer read lines buffer[k] up with the weight that returns a cycle later.
    always_ff @(posedge clk) begin
        if ((state_reg == LOAD) && in_valid)
            buf_mem[k_reg] <= in_data;
        buf_rd_reg <= buf_mem[k_reg];
    end

    assign prod     = {{DATA_W{w_rdata[DATA_W-1]}}, w_rdata} *
                      {{DATA_W{buf_rd_reg[DATA_W-1]}}, buf_rd_reg};
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){b_rdata[DATA_W-1]}}, b_rdata};

    // The first product of a neuron replaces the stale sum with the freshly read bias.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg        <= '0;
            bias_phase_reg <= 1'b0;
        end else begin
            bias_phase_reg <= (state_reg == MAC) && (k_reg == '0);
            if (((state_reg == MAC) && (k_reg != '0)) || (state_reg == DRAIN))
                acc_reg <= (bias_phase_reg ? bias_ext : acc_reg) + prod_ext;
        end
    end

    assign shifted = acc_reg >>> SHIFT;

    always_comb begin
        sat = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX)
            sat = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[DATA_W-1:0];
    end

    always_comb begin
        w_addr = '0;
        if (state_reg == MAC)
            w_addr = WA_W'(n_reg) * WA_W'(INPUT_SIZE) + WA_W'(k_reg);
    end

    assign in_ready  = (state_reg == LOAD);
    assign w_rd_en   = (state_reg == MAC);
    assign b_rd_en   = (state_reg == MAC) && (k_reg == '0);
    assign b_addr    = b_rd_en ? n_reg : '0;
    assign out_valid = (state_reg == OUT);
    assign out_data  = out_valid ? sat : '0;
    assign out_idx   = out_valid ? n_reg : '0;
    assign out_last  = out_valid && last_n;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: two instances (relu/SHIFT=0 and none/SHIFT=4) run in lockstep
// from a vector table; a scoreboard queue checks every output handshake.
module tb_fc_sequencer;
    localparam int IS = 4;
    localparam int OS = 3;
    localparam int NV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] in_data = '0;

    logic       in_ready_a, w_rd_en_a, b_rd_en_a, out_valid_a, out_last_a, busy_a, done_a;
    logic [3:0] w_addr_a;
    logic [1:0] b_addr_a, out_idx_a;
    logic [7:0] w_rdata_a = '0, b_rdata_a = '0, out_data_a;
    logic       in_ready_b, w_rd_en_b, b_rd_en_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [3:0] w_addr_b;
    logic [1:0] b_addr_b, out_idx_b;
    logic [7:0] w_rdata_b = '0, b_rdata_b = '0, out_data_b;

    fc_sequencer #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_W(8), .ACC_W(24),
                   .SHIFT(0), .ACTIVATION("relu")) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .w_rd_en(w_rd_en_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
        .b_rd_en(b_rd_en_a), .b_addr(b_addr_a), .b_rdata(b_rdata_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_idx(out_idx_a), .out_last(out_last_a), .busy(busy_a), .done(done_a));

    fc_sequencer #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_W(8), .ACC_W(24),
                   .SHIFT(4), .ACTIVATION("none")) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
        .b_rd_en(b_rd_en_b), .b_addr(b_addr_b), .b_rdata(b_rdata_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_idx(out_idx_b), .out_last(out_last_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight/bias memories with one-cycle registered read, one read port per instance.
    logic [7:0] w_mem [IS*OS];
    logic [7:0] b_mem [OS];
    always @(posedge clk) begin
        if (w_rd_en_a) w_rdata_a <= w_mem[w_addr_a];
        if (b_rd_en_a) b_rdata_a <= b_mem[b_addr_a];
        if (w_rd_en_b) w_rdata_b <= w_mem[w_addr_b];
        if (b_rd_en_b) b_rdata_b <= b_mem[b_addr_b];
    end

    typedef struct packed {
        logic [0:IS-1][7:0]    x;
        logic [0:IS*OS-1][7:0] w;
        logic [0:OS-1][7:0]    b;
        logic [0:OS-1][7:0]    ea;   // expected, relu SHIFT=0
        logic [0:OS-1][7:0]    eb;   // expected, none SHIFT=4
    } vec_t;
    vec_t vecs [NV];

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] da;
        logic [7:0] db;
        logic       last;
    } exp_t;
    exp_t sb [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor state
    int   last_in_edge = 0;
    bit   vpending = 0;
    bit   timing_en = 0;
    bit   expect_done = 0;
    bit   prev_next_neuron = 0;
    bit   prev_stall = 0;
    logic [7:0] hold_data;
    logic [1:0] hold_idx;
    logic       hold_last;
    int   exp_w = 0;
    int   exp_b = 0;
    exp_t e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                exp_w = 0; exp_b = 0;
                expect_done = 0; prev_next_neuron = 0; prev_stall = 0; vpending = 0;
            end else begin
                if (in_valid && in_ready_a) begin
                    last_in_edge = cyc + 1;
                    vpending = 1;
                end
                if (out_valid_a && vpending) begin
                    vpending = 0;
                    check("first_valid_latency", cyc - last_in_edge, 5);
                end
                if (done_a || expect_done)
                    check("done_pulse", {done_a, done_b}, {2{expect_done}});
                if (done_a) begin
                    check("busy_low_at_done", {busy_a, busy_b}, 0);
                    if (timing_en) check("pass_cycles", cyc - last_in_edge, OS * (IS + 2));
                end
                if (prev_next_neuron)
                    check("next_mac_no_bubble", {w_rd_en_a, b_rd_en_a}, 2'b11);
                if (prev_stall)
                    check("stall_hold", {out_valid_a, out_data_a, out_idx_a, out_last_a},
                          {1'b1, hold_data, hold_idx, hold_last});
                if (out_valid_a && !out_ready)
                    check("no_read_in_stall", w_rd_en_a, 0);
                if (b_rd_en_a) begin
                    check("b_addr", b_addr_a, exp_b);
                    check("b_align_k0", w_addr_a, exp_b * IS);
                    exp_b = (exp_b == OS - 1) ? 0 : exp_b + 1;
                end
                if (w_rd_en_a) begin
                    check("w_addr", w_addr_a, exp_w);
                    exp_w = (exp_w == IS * OS - 1) ? 0 : exp_w + 1;
                end
                expect_done = 0; prev_next_neuron = 0; prev_stall = 0;
                if (out_valid_a && out_ready) begin
                    $display("[%0d] out idx=%0d relu=%0d none_s4=%0d last=%0d", cyc, out_idx_a,
                             $signed(out_data_a), $signed(out_data_b), out_last_a);
                    check("output_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("out_idx", out_idx_a, e.idx);
                        check("out_data_relu", out_data_a, e.da);
                        check("out_data_none_s4", {out_valid_b, out_data_b}, {1'b1, e.db});
                        check("out_last", out_last_a, e.last);
                    end
                    expect_done = out_last_a;
                    prev_next_neuron = !out_last_a;
                end else if (out_valid_a) begin
                    prev_stall = 1;
                    hold_data = out_data_a; hold_idx = out_idx_a; hold_last = out_last_a;
                end
            end
        end
    end

    task automatic run_pass(input int v, input bit stall, input bit gaps,
                            input bit mid_start, input bit abort);
        bit seen;
        exp_t x;
        for (int i = 0; i < IS * OS; i++) w_mem[i] = vecs[v].w[i];
        for (int n = 0; n < OS; n++) begin
            b_mem[n] = vecs[v].b[n];
            x.idx = 2'(n); x.da = vecs[v].ea[n]; x.db = vecs[v].eb[n]; x.last = (n == OS - 1);
            sb.push_back(x);
        end
        timing_en = !stall && !abort;
        out_ready = !stall;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_ready_after_start", {busy_a, in_ready_a, busy_b}, 3'b111);
        for (int i = 0; i < IS; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                repeat ($urandom_range(1, 3)) tick();
            end
            in_valid = 1'b1;
            in_data = vecs[v].x[i];
            if (mid_start && i == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (stall) begin
            seen = 0;
            for (int t = 0; t < 50 && !seen; t++) begin
                if (out_valid_a) seen = 1; else tick();
            end
            check("stall_valid_seen", seen, 1);
            repeat (5) tick();
            out_ready = 1'b1;
        end
        if (abort) begin
            seen = 0;
            for (int t = 0; t < 60 && !seen; t++) begin
                tick();
                if (w_rd_en_a && w_addr_a == 4'(IS + 1)) seen = 1;
            end
            check("abort_neuron1_mac_seen", seen, 1);
            rst = 1'b1;
            tick();
            check("abort_reset_outputs_a", {in_ready_a, w_rd_en_a, b_rd_en_a, out_valid_a,
                  out_last_a, busy_a, done_a, out_data_a, out_idx_a, w_addr_a, b_addr_a}, 0);
            check("abort_reset_outputs_b", {in_ready_b, w_rd_en_b, b_rd_en_b, out_valid_b,
                  out_last_b, busy_b, done_b, out_data_b, out_idx_b, w_addr_b, b_addr_b}, 0);
            rst = 1'b0;
            repeat (3) tick();
        end else begin
            seen = 0;
            for (int t = 0; t < 200 && !seen; t++) begin
                tick();
                if (done_a) seen = 1;
            end
            check("pass_completes", seen, 1);
            check("scoreboard_drained", sb.size(), 0);
            tick();
        end
    endtask

    initial begin
        vecs[0].x  = {8'd1, 8'd2, 8'd3, 8'd4};
        vecs[0].w  = {8'd1, 8'd1, 8'd1, 8'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 8'd3, 8'd0, 8'd1};
        vecs[0].b  = {8'd0, 8'd2, 8'hFD};
        vecs[0].ea = {8'd10, 8'd0, 8'd7};
        vecs[0].eb = {8'd0, 8'hFF, 8'd0};
        vecs[1].x  = {4{8'd127}};
        vecs[1].w  = {{4{8'd127}}, {4{8'h80}}, {4{8'd0}}};
        vecs[1].b  = {8'd0, 8'd0, 8'h80};
        vecs[1].ea = {8'd127, 8'd0, 8'd0};
        vecs[1].eb = {8'd127, 8'h80, 8'hF8};
        vecs[2].x  = {4{8'd16}};
        vecs[2].w  = {{4{8'd2}}, 8'd1, 8'hFF, 8'd1, 8'hFF, 8'hFF, 8'd0, 8'd0, 8'd0};
        vecs[2].b  = {8'd8, 8'd5, 8'hFF};
        vecs[2].ea = {8'd127, 8'd5, 8'd0};
        vecs[2].eb = {8'd8, 8'd0, 8'hFE};
        vecs[3].x  = {8'hFD, 8'd5, 8'hF9, 8'd100};
        vecs[3].w  = vecs[0].w;
        vecs[3].b  = {8'd0, 8'd2, 8'hFD};
        vecs[3].ea = {8'd95, 8'd0, 8'd112};
        vecs[3].eb = {8'd5, 8'hFA, 8'd7};

        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs_a", {in_ready_a, w_rd_en_a, b_rd_en_a, out_valid_a, out_last_a,
              busy_a, done_a, out_data_a, out_idx_a, w_addr_a, b_addr_a}, 0);
        check("reset_outputs_b", {in_ready_b, w_rd_en_b, b_rd_en_b, out_valid_b, out_last_b,
              busy_b, done_b, out_data_b, out_idx_b, w_addr_b, b_addr_b}, 0);
        rst = 1'b0;

        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (2) begin
            tick();
            check("idle_ignores_in_valid", {in_ready_a, in_ready_b, busy_a}, 0);
        end
        in_valid = 1'b0;
        tick();

        for (int v = 0; v < NV; v++)
            run_pass(v, v == 1, v == 2, v == 3, 1'b0);
        run_pass(2, 1'b0, 1'b0, 1'b0, 1'b1);
        run_pass(3, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
